// File: rtl/counter_rr_scheduler.sv
// Shared signed counter with a round-robin arbiter in front of it.
// Each cycle at most one requester is granted; its delta is added to the
// counter and the pre-add value is returned one cycle later.
module counter_rr_scheduler #(
  parameter int unsigned      N_REQ = 4,
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                     CLK,
  input  logic                     ASYNCRESETN,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_delta,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     clear,
  input  logic                     hold,
  output logic [WIDTH-1:0]         count,
  output logic                     resp_valid,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [WIDTH-1:0]         resp_value,
  output logic                     overflow
);

  localparam int unsigned IdW = $clog2(N_REQ);

  logic [WIDTH-1:0] count_q, count_d;
  logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             resp_valid_q, resp_valid_d;
  logic [IdW-1:0]   resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_value_q, resp_value_d;
  logic             overflow_q, overflow_d;

  logic [N_REQ-1:0] grant;
  logic [IdW-1:0]   grant_id;
  logic             transfer;
  logic [WIDTH-1:0] sel_delta;
  logic [WIDTH-1:0] sum;
  logic             ovf_now;

  // Round-robin search starting at rr_ptr; blocked entirely by clear or hold.
  always_comb begin
    logic           found;
    logic [IdW-1:0] cand;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand     = '0;
    if (!clear && !hold) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        cand = IdW'((32'(rr_ptr_q) + k) % N_REQ);
        if (!found && req_valid[cand]) begin
          grant[cand] = 1'b1;
          grant_id    = cand;
          found       = 1'b1;
        end
      end
    end
  end

  // Ready is forced low while reset is asserted, even between clock edges.
  assign req_ready = grant & {N_REQ{ASYNCRESETN}};
  assign transfer  = |req_ready;

  // Adder datapath and signed-overflow detection on the granted delta.
  assign sel_delta = req_delta[grant_id*WIDTH +: WIDTH];
  assign sum       = count_q + sel_delta;
  assign ovf_now   = (count_q[WIDTH-1] == sel_delta[WIDTH-1]) &&
                     (sum[WIDTH-1] != count_q[WIDTH-1]);

  // Next-state: clear has priority; otherwise a transfer updates everything.
  always_comb begin
    count_d      = count_q;
    rr_ptr_d     = rr_ptr_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_value_d = resp_value_q;
    overflow_d   = overflow_q;
    if (clear) begin
      count_d    = INIT;
      rr_ptr_d   = '0;
      overflow_d = 1'b0;
    end else if (transfer) begin
      count_d      = sum;
      rr_ptr_d     = (grant_id == IdW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
      resp_valid_d = 1'b1;
      resp_id_d    = grant_id;
      resp_value_d = count_q;
      overflow_d   = overflow_q | ovf_now;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      count_q      <= INIT;
      rr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_value_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_value_q <= resp_value_d;
      overflow_q   <= overflow_d;
    end
  end

  assign count      = count_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_value = resp_value_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Bench for counter_rr_scheduler: vector table with a response scoreboard,
// plus hand-written asynchronous reset sequences.
module tb_counter_rr_scheduler;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 16;

  logic                   CLK;
  logic                   ASYNCRESETN;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_delta;
  logic [N_REQ-1:0]       req_ready;
  logic                   clear;
  logic                   hold;
  logic [WIDTH-1:0]       count;
  logic                   resp_valid;
  logic [1:0]             resp_id;
  logic [WIDTH-1:0]       resp_value;
  logic                   overflow;

  counter_rr_scheduler #(
    .N_REQ(N_REQ),
    .WIDTH(WIDTH),
    .INIT (16'h0000)
  ) dut (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .req_valid  (req_valid),
    .req_delta  (req_delta),
    .req_ready  (req_ready),
    .clear      (clear),
    .hold       (hold),
    .count      (count),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_value (resp_value),
    .overflow   (overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  valid;
    logic [63:0] delta;
    logic        clr;
    logic        hld;
    logic [3:0]  exp_ready;
    logic [15:0] exp_count;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] value;
  } resp_t;

  vec_t  vecs[$];
  resp_t sb[$];
  int    n_pass  = 0;
  int    n_total = 0;
  logic [15:0] prev_count = 16'h0000;
  logic [1:0]  last_id    = 2'd0;
  logic [15:0] last_val   = 16'h0000;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [15:0] d3, input logic c,
                              input logic h, input logic [3:0] r, input logic [15:0] cnt,
                              input logic o);
    vec_t x;
    x.valid = v; x.delta = {d3, d2, d1, d0}; x.clr = c; x.hld = h;
    x.exp_ready = r; x.exp_count = cnt; x.exp_ovf = o;
    return x;
  endfunction

  // One cycle: drive at negedge, check grant, push expected response,
  // then after the edge check count/overflow and pop the response.
  task automatic apply(input vec_t v, input int n);
    resp_t e;
    resp_t got_e;
    string tag;
    tag = $sformatf("v%0d", n);
    @(negedge CLK);
    req_valid = v.valid; req_delta = v.delta; clear = v.clr; hold = v.hld;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(v.exp_ready));
    if (v.exp_ready != 4'b0) begin
      e.id = 2'd0;
      for (int i = 0; i < 4; i++) if (v.exp_ready[i]) e.id = 2'(i);
      e.value = prev_count;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
    check({tag, "_count"}, 32'(count), 32'(v.exp_count));
    check({tag, "_ovf"}, 32'(overflow), 32'(v.exp_ovf));
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      got_e = sb.pop_front();
      check({tag, "_resp_id"}, 32'(resp_id), 32'(got_e.id));
      check({tag, "_resp_value"}, 32'(resp_value), 32'(got_e.value));
      last_id  = got_e.id;
      last_val = got_e.value;
    end else begin
      check({tag, "_resp_id_hold"}, 32'(resp_id), 32'(last_id));
      check({tag, "_resp_value_hold"}, 32'(resp_value), 32'(last_val));
    end
    prev_count = v.exp_count;
  endtask

  initial begin
    ASYNCRESETN = 1'b0;
    req_valid = 4'b1111; req_delta = '0; clear = 1'b0; hold = 1'b0;

    // Reset state, with requests present that must not be granted.
    #12;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_id", 32'(resp_id), 32'h0);
    check("rst_resp_value", 32'(resp_value), 32'h0);
    @(negedge CLK);
    req_valid = 4'b0000;
    ASYNCRESETN = 1'b1;

    // Single requester, +1 five times.
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(4'b0001, 16'd1, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 4'b0001,
                        16'(i + 1), 1'b0));
    // Clear, then all four valid: grants 0,1,2,3,0.
    vecs.push_back(mk(4'b1111, 16'd1, 16'd2, 16'd3, 16'd4, 1'b1, 1'b0, 4'b0000, 16'd0, 1'b0));
    vecs.push_back(mk(4'b1111, 16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 1'b0, 4'b0001, 16'd1, 1'b0));
    vecs.push_back(mk(4'b1111, 16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 1'b0, 4'b0010, 16'd3, 1'b0));
    vecs.push_back(mk(4'b1111, 16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 1'b0, 4'b0100, 16'd6, 1'b0));
    vecs.push_back(mk(4'b1111, 16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 1'b0, 4'b1000, 16'd10, 1'b0));
    vecs.push_back(mk(4'b1111, 16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 1'b0, 4'b0001, 16'd11, 1'b0));
    // Overflow: clear, load 7FFF, +1, -1, clear.
    vecs.push_back(mk(4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 4'b0000, 16'd0, 1'b0));
    vecs.push_back(mk(4'b0001, 16'h7FFF, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 4'b0001, 16'h7FFF, 1'b0));
    vecs.push_back(mk(4'b0010, 16'd0, 16'd1, 16'd0, 16'd0, 1'b0, 1'b0, 4'b0010, 16'h8000, 1'b1));
    vecs.push_back(mk(4'b0100, 16'd0, 16'd0, 16'hFFFF, 16'd0, 1'b0, 1'b0, 4'b0100, 16'h7FFF, 1'b1));
    vecs.push_back(mk(4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 4'b0000, 16'd0, 1'b0));
    // Clear+hold with req 2, then hold alone for three cycles.
    vecs.push_back(mk(4'b0100, 16'd0, 16'd0, 16'd5, 16'd0, 1'b1, 1'b1, 4'b0000, 16'd0, 1'b0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(4'b0100, 16'd0, 16'd0, 16'd5, 16'd0, 1'b0, 1'b1, 4'b0000, 16'd0, 1'b0));
    // Pointer wrap: move ptr to 1, lone req 3, then reqs 1 and 3.
    vecs.push_back(mk(4'b0001, 16'd1, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 4'b0001, 16'd1, 1'b0));
    vecs.push_back(mk(4'b1000, 16'd0, 16'd0, 16'd0, 16'd2, 1'b0, 1'b0, 4'b1000, 16'd3, 1'b0));
    vecs.push_back(mk(4'b1010, 16'd0, 16'd10, 16'd0, 16'd2, 1'b0, 1'b0, 4'b0010, 16'd13, 1'b0));
    vecs.push_back(mk(4'b1000, 16'd0, 16'd0, 16'd0, 16'd2, 1'b0, 1'b0, 4'b1000, 16'd15, 1'b0));
    // Hold with everyone valid, idle cycle, then a negative delta.
    vecs.push_back(mk(4'b1111, 16'd1, 16'd1, 16'd1, 16'd1, 1'b0, 1'b1, 4'b0000, 16'd15, 1'b0));
    vecs.push_back(mk(4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 4'b0000, 16'd15, 1'b0));
    vecs.push_back(mk(4'b0100, 16'd0, 16'd0, 16'hFFEC, 16'd0, 1'b0, 1'b0, 4'b0100, 16'hFFFB,
                      1'b0));

    foreach (vecs[i]) apply(vecs[i], i);

    // Reset pulsed between edges while a grant is pending: nothing lands.
    @(negedge CLK);
    req_valid = 4'b0001; req_delta = 64'd7; clear = 1'b0; hold = 1'b0;
    #1;
    check("ar1_ready_pre", 32'(req_ready), 32'h1);
    ASYNCRESETN = 1'b0;
    #1;
    check("ar1_ready", 32'(req_ready), 32'h0);
    check("ar1_count", 32'(count), 32'h0);
    check("ar1_resp_id", 32'(resp_id), 32'h0);
    check("ar1_resp_value", 32'(resp_value), 32'h0);
    req_valid = 4'b0000;
    #1;
    ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1;
    check("ar1_resp_valid_after", 32'(resp_valid), 32'h0);
    check("ar1_count_after", 32'(count), 32'h0);

    // Transfer lands, then reset drops the pending response pulse.
    @(negedge CLK);
    req_valid = 4'b0001; req_delta = 64'd7;
    @(posedge CLK);
    #1;
    req_valid = 4'b0000;
    check("ar2_count_pre", 32'(count), 32'h7);
    check("ar2_resp_valid_pre", 32'(resp_valid), 32'h1);
    ASYNCRESETN = 1'b0;
    #1;
    check("ar2_resp_valid", 32'(resp_valid), 32'h0);
    check("ar2_count", 32'(count), 32'h0);
    check("ar2_ovf", 32'(overflow), 32'h0);
    #1;
    ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1;
    check("ar2_resp_valid_after", 32'(resp_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
